// File: rtl/phase_write.sv
// -----------------------------------------------------------------------------
// phase_write
//   Imposes a programmed spin state onto the coupled oscillator array before
//   an anneal run. For a programmed hold period every selected oscillator is
//   forced onto a reference square wave (in phase for spin=1, anti-phase for
//   spin=0); the array is then released to evolve freely.
//
//   Optional feature macro: PHASE_WRITE_MASK_EN
//     defined   : adds spin_mask; only masked-in spins are forced, the rest
//                 keep their current phase (force_en=0, force_val=0).
//     undefined : all N spins are forced.
//
// Ports
//   clk          in   1      clock, all state on posedge
//   rstn         in   1      asynchronous active-low reset
//   start        in   1      write request, accepted only in IDLE
//   spins_in     in   N      target spins, 1 = in phase with ref_wave
//   spin_mask    in   N      (PHASE_WRITE_MASK_EN only) per-spin force select
//   hold_cycles  in   CNT_W  force duration in cycles (0 treated as 1)
//   half_period  in   CNT_W  ref_wave half period in cycles (0 treated as 1)
//   ref_wave     out  1      reference square wave
//   force_en     out  N      per-spin force enable
//   force_val    out  N      per-spin forced level
//   busy         out  1      high from accept until back in IDLE
//   done         out  1      one-cycle completion pulse
// -----------------------------------------------------------------------------
module phase_write #(
    parameter int unsigned N     = 3,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [N-1:0]     spins_in,
`ifdef PHASE_WRITE_MASK_EN
    input  logic [N-1:0]     spin_mask,
`endif
    input  logic [CNT_W-1:0] hold_cycles,
    input  logic [CNT_W-1:0] half_period,
    output logic             ref_wave,
    output logic [N-1:0]     force_en,
    output logic [N-1:0]     force_val,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FORCE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state,     w_state;
    logic [N-1:0]     r_spins,     w_spins;
    logic [N-1:0]     r_mask,      w_mask;
    logic [CNT_W-1:0] r_hold,      w_hold;
    logic [CNT_W-1:0] r_half,      w_half;
    logic [CNT_W-1:0] r_phase_cnt, w_phase_cnt;
    logic [CNT_W-1:0] r_hold_cnt,  w_hold_cnt;
    logic             r_ref,       w_ref;
    logic [N-1:0]     r_force_en,  w_force_en;
    logic [N-1:0]     r_force_val, w_force_val;
    logic             r_busy,      w_busy;
    logic             r_done,      w_done;

    logic [N-1:0]     w_mask_in;

`ifdef PHASE_WRITE_MASK_EN
    assign w_mask_in = spin_mask;
`else
    assign w_mask_in = '1;
`endif

    assign ref_wave  = r_ref;
    assign force_en  = r_force_en;
    assign force_val = r_force_val;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_spins     <= '0;
            r_mask      <= '0;
            r_hold      <= CNT_W'(1);
            r_half      <= CNT_W'(1);
            r_phase_cnt <= '0;
            r_hold_cnt  <= '0;
            r_ref       <= 1'b0;
            r_force_en  <= '0;
            r_force_val <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_spins     <= w_spins;
            r_mask      <= w_mask;
            r_hold      <= w_hold;
            r_half      <= w_half;
            r_phase_cnt <= w_phase_cnt;
            r_hold_cnt  <= w_hold_cnt;
            r_ref       <= w_ref;
            r_force_en  <= w_force_en;
            r_force_val <= w_force_val;
            r_busy      <= w_busy;
            r_done      <= w_done;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_spins     = r_spins;
        w_mask      = r_mask;
        w_hold      = r_hold;
        w_half      = r_half;
        w_phase_cnt = r_phase_cnt;
        w_hold_cnt  = r_hold_cnt;
        w_ref       = r_ref;
        w_force_en  = r_force_en;
        w_force_val = r_force_val;
        w_busy      = r_busy;
        w_done      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state     = S_FORCE;
                    w_spins     = spins_in;
                    w_mask      = w_mask_in;
                    // Zero limits are clamped to 1 at latch time so the
                    // terminal compares below never underflow.
                    w_hold      = (hold_cycles == '0) ? CNT_W'(1) : hold_cycles;
                    w_half      = (half_period == '0) ? CNT_W'(1) : half_period;
                    w_phase_cnt = '0;
                    w_hold_cnt  = '0;
                    w_ref       = 1'b0;
                    w_force_en  = w_mask_in;
                    // ref_wave restarts at 0, so spin=1 drives 0 and spin=0 drives 1.
                    w_force_val = ~spins_in & w_mask_in;
                    w_busy      = 1'b1;
                end
            end

            S_FORCE: begin
                if (r_hold_cnt == r_hold - CNT_W'(1)) begin
                    w_state     = S_DONE;
                    w_force_en  = '0;
                    w_force_val = '0;
                    w_done      = 1'b1;
                end else begin
                    w_hold_cnt = r_hold_cnt + CNT_W'(1);
                    if (r_phase_cnt == r_half - CNT_W'(1)) begin
                        w_phase_cnt = '0;
                        w_ref       = ~r_ref;
                    end else begin
                        w_phase_cnt = r_phase_cnt + CNT_W'(1);
                    end
                    // Derived from the next ref value so force_val and ref_wave
                    // update on the same edge with no skew.
                    w_force_val = (w_ref ? r_spins : ~r_spins) & r_mask;
                end
            end

            S_DONE: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end

            default: begin
                w_state     = S_IDLE;
                w_force_en  = '0;
                w_force_val = '0;
                w_busy      = 1'b0;
            end
        endcase
    end

endmodule
